// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: shared types for the tinyalu datapath and its front-end arbiter.
//   operation_t : 3-bit tinyalu opcode encoding (5 and 6 are unused codes)
//   arb_state_t : tinyalu_arbiter FSM states
//   is_alu_op() : 1 for opcodes that need the shared ALU, 0 for locally completed ones
package tinyalu_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } operation_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  // Result reported when the ALU never raises done.
  localparam logic [15:0] TIMEOUT_RESULT = 16'hFFFF;

  function automatic logic is_alu_op(input operation_t op);
    logic r;
    case (op)
      add_op, and_op, xor_op, mul_op: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tinyalu_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority selector.
//   req   [N-1:0]  : request vector
//   ptr   [IW-1:0] : index that currently has highest priority
//   grant [N-1:0]  : one-hot grant (all zero when no request)
//   idx   [IW-1:0] : encoded index of the granted request
//   valid          : at least one request present
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from ptr upward with wrap-around; the first set request wins.
  always_comb begin
    int   j_s;
    logic hit_s;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j_s   = 0;
    hit_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      j_s      = int'(ptr) + i;
      j_s      = (j_s >= N) ? (j_s - N) : j_s;
      hit_s    = !valid && req[j_s];
      grant[j_s] = hit_s;
      idx      = hit_s ? IW'(j_s) : idx;
      valid    = valid | hit_s;
    end
  end

endmodule

// File: rtl/tinyalu_arbiter.sv
// tinyalu_arbiter: shares one tinyalu between NUM_REQ requesters.
// Round-robin grant, start/done sequencing, local completion of non-ALU
// opcodes, and abort with err=1 / result 0xFFFF after TIMEOUT start cycles.
//   clk, reset_n                 : clock, async active-low reset
//   req / req_A / req_B / req_op : per-requester request and operands (slice i = requester i)
//   ack, rsp_result, rsp_err     : one-hot one-cycle completion with result and timeout flag
//   busy                         : FSM not in IDLE
//   alu_A / alu_B / alu_op / alu_start, alu_done / alu_result : tinyalu side
module tinyalu_arbiter
  import tinyalu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_A,
  input  logic [NUM_REQ*8-1:0] req_B,
  input  logic [NUM_REQ*3-1:0] req_op,
  output logic [NUM_REQ-1:0]   ack,
  output logic [15:0]          rsp_result,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [7:0]           alu_A,
  output logic [7:0]           alu_B,
  output logic [2:0]           alu_op,
  output logic                 alu_start,
  input  logic                 alu_done,
  input  logic [15:0]          alu_result
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t         state_r, state_s;
  logic [7:0]         a_r, a_s, b_r, b_s;
  operation_t         op_r, op_s;
  logic [IW-1:0]      idx_r, idx_s, ptr_r, ptr_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic [NUM_REQ-1:0] ack_r, ack_s;
  logic [15:0]        result_r, result_s;
  logic               err_r, err_s, start_r, start_s;

  logic [NUM_REQ-1:0] pick_grant_s;
  logic [IW-1:0]      pick_idx_s;
  logic               pick_valid_s;
  logic [7:0]         pick_a_s, pick_b_s;
  operation_t         pick_op_s;
  logic [NUM_REQ-1:0] idx_onehot_s;

  // ptr_r holds the index with highest priority: 0 after reset, last granted + 1 afterwards.
  rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .req   (req),
    .ptr   (ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .valid (pick_valid_s)
  );

  assign pick_a_s     = req_A[int'(pick_idx_s)*8 +: 8];
  assign pick_b_s     = req_B[int'(pick_idx_s)*8 +: 8];
  assign pick_op_s    = operation_t'(req_op[int'(pick_idx_s)*3 +: 3]);
  assign idx_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_r;

  // Next-state and next-output logic; outputs are registered so they line up with the state.
  always_comb begin
    state_s  = state_r;
    a_s      = a_r;
    b_s      = b_r;
    op_s     = op_r;
    idx_s    = idx_r;
    ptr_s    = ptr_r;
    cnt_s    = cnt_r;
    ack_s    = '0;
    result_s = 16'h0000;
    err_s    = 1'b0;
    start_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          a_s   = pick_a_s;
          b_s   = pick_b_s;
          op_s  = pick_op_s;
          idx_s = pick_idx_s;
          cnt_s = '0;
          if (is_alu_op(pick_op_s)) begin
            state_s = ISSUE;
            start_s = 1'b1;
          end else begin
            // Local opcode: acknowledge with result 0 without touching the ALU.
            state_s = RESP;
            ack_s   = pick_grant_s;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (alu_done) begin
          state_s  = RESP;
          ack_s    = idx_onehot_s;
          result_s = alu_result;
        end else if (cnt_r == CW'(TIMEOUT - 1)) begin
          state_s  = RESP;
          ack_s    = idx_onehot_s;
          result_s = TIMEOUT_RESULT;
          err_s    = 1'b1;
        end else begin
          start_s = 1'b1;
          cnt_s   = cnt_r + CW'(1);
        end
      end
      RESP: begin
        state_s = IDLE;
        ptr_s   = (idx_r == IW'(NUM_REQ - 1)) ? '0 : idx_r + IW'(1);
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      a_r      <= 8'h00;
      b_r      <= 8'h00;
      op_r     <= no_op;
      idx_r    <= '0;
      ptr_r    <= '0;
      cnt_r    <= '0;
      ack_r    <= '0;
      result_r <= 16'h0000;
      err_r    <= 1'b0;
      start_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      a_r      <= a_s;
      b_r      <= b_s;
      op_r     <= op_s;
      idx_r    <= idx_s;
      ptr_r    <= ptr_s;
      cnt_r    <= cnt_s;
      ack_r    <= ack_s;
      result_r <= result_s;
      err_r    <= err_s;
      start_r  <= start_s;
    end
  end

  assign ack        = ack_r;
  assign rsp_result = result_r;
  assign rsp_err    = err_r;
  assign busy       = (state_r != IDLE);
  assign alu_A      = a_r;
  assign alu_B      = b_r;
  assign alu_op     = op_r;
  assign alu_start  = start_r;

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Directed self-checking bench for tinyalu_arbiter with a behavioural ALU.
module tb_tinyalu_arbiter;
  import tinyalu_pkg::*;

  localparam int NR = 4;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NR-1:0]   req;
  logic [NR*8-1:0] req_A, req_B;
  logic [NR*3-1:0] req_op;
  logic [NR-1:0]   ack;
  logic [15:0]     rsp_result;
  logic            rsp_err, busy;
  logic [7:0]      alu_A, alu_B;
  logic [2:0]      alu_op;
  logic            alu_start;
  logic            alu_done;
  logic [15:0]     alu_result;

  int vectors = 0;
  int miscompares = 0;
  int start_total = 0;
  logic alu_hang = 1'b0;
  int alu_cnt = 0;
  logic [NR-1:0] hold = '0;

  int          order_q[$];
  logic [15:0] res_q[$];
  logic        err_q[$];

  tinyalu_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_A(req_A), .req_B(req_B),
    .req_op(req_op), .ack(ack), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .busy(busy), .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: done pulses in the second start cycle unless hung.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_cnt <= 0; alu_done <= 1'b0; alu_result <= 16'h0000;
    end else if (!alu_start || alu_hang) begin
      alu_cnt <= 0; alu_done <= 1'b0;
    end else if (alu_cnt == 0) begin
      alu_done <= 1'b1;
      alu_cnt  <= alu_cnt + 1;
      case (alu_op)
        3'b001:  alu_result <= {8'h00, alu_A} + {8'h00, alu_B};
        3'b010:  alu_result <= {8'h00, alu_A & alu_B};
        3'b011:  alu_result <= {8'h00, alu_A ^ alu_B};
        3'b100:  alu_result <= {8'h00, alu_A} * {8'h00, alu_B};
        default: alu_result <= 16'h0000;
      endcase
    end else begin
      alu_done <= 1'b0;
      alu_cnt  <= alu_cnt + 1;
    end
  end

  always @(negedge clk) if (alu_start) start_total++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input operation_t op, input logic [7:0] a, input logic [7:0] b);
    req_A[i*8 +: 8]  = a;
    req_B[i*8 +: 8]  = b;
    req_op[i*3 +: 3] = op;
    req[i]           = 1'b1;
  endtask

  // Gather n acks (bounded); non-held requesters drop req in their ack cycle.
  task automatic collect(input int n, input int max_cyc);
    int got = 0;
    int cyc = 0;
    order_q.delete(); res_q.delete(); err_q.delete();
    while (got < n && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) begin
        chk("ack_onehot", $countones(ack), 1);
        for (int i = 0; i < NR; i++) begin
          if (ack[i]) begin
            order_q.push_back(i);
            if (!hold[i]) req[i] = 1'b0;
          end
        end
        res_q.push_back(rsp_result);
        err_q.push_back(rsp_err);
        got++;
      end
    end
    chk("ack_count", got, n);
  endtask

  task automatic wait_start(input int max_cyc);
    int cyc = 0;
    while (!alu_start && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    chk("start_seen", alu_start, 1'b1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    hold = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int s0;
    int acks;
    int exp_ord[4];
    logic [15:0] exp_res[4];
    req = '0; req_A = '0; req_B = '0; req_op = '0;
    do_reset();

    // Reset state
    chk("rst_ack", ack, 4'b0000);
    chk("rst_result", rsp_result, 16'h0000);
    chk("rst_err", rsp_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", alu_start, 1'b0);
    chk("rst_alu_A", alu_A, 8'h00);
    chk("rst_alu_B", alu_B, 8'h00);
    chk("rst_alu_op", alu_op, no_op);

    // Single add; live operand change must not reach the ALU
    s0 = start_total;
    set_req(0, add_op, 8'h12, 8'h34);
    wait_start(5);
    chk("add_alu_A", alu_A, 8'h12);
    chk("add_alu_B", alu_B, 8'h34);
    chk("add_alu_op", alu_op, add_op);
    chk("add_busy", busy, 1'b1);
    req_A[7:0] = 8'h77;
    @(negedge clk);
    chk("add_latched_A", alu_A, 8'h12);
    collect(1, 20);
    if (res_q.size() == 1) begin
      chk("add_order", order_q[0], 0);
      chk("add_result", res_q[0], 16'h0046);
      chk("add_err", err_q[0], 1'b0);
    end
    chk("add_start_cycles", start_total - s0, 2);

    // All four simultaneously after reset: order 0,1,2,3
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, mul_op, 8'hFF, 8'hFF);
    collect(4, 60);
    for (int k = 0; k < 4 && k < order_q.size(); k++) begin
      chk($sformatf("mul4_order%0d", k), order_q[k], k);
      chk($sformatf("mul4_result%0d", k), res_q[k], 16'hFE01);
      chk($sformatf("mul4_err%0d", k), err_q[k], 1'b0);
    end

    // Fairness: 1 and 3 held continuously, then 2 joins
    set_req(1, and_op, 8'hF0, 8'h3C);
    set_req(3, and_op, 8'hAA, 8'h0F);
    hold = 4'b1010;
    collect(4, 60);
    exp_ord = '{1, 3, 1, 3};
    exp_res = '{16'h0030, 16'h000A, 16'h0030, 16'h000A};
    for (int k = 0; k < 4 && k < order_q.size(); k++) begin
      chk($sformatf("fair_order%0d", k), order_q[k], exp_ord[k]);
      chk($sformatf("fair_result%0d", k), res_q[k], exp_res[k]);
    end
    set_req(2, and_op, 8'hFF, 8'h81);
    collect(2, 30);
    if (order_q.size() == 2) begin
      chk("late2_first", order_q[0], 1);
      chk("late2_served", order_q[1], 2);
      chk("late2_result", res_q[1], 16'h0081);
    end
    hold = '0;
    req = '0;

    // Local ops on requester 2: ack one cycle after the request, ALU untouched
    @(negedge clk);
    s0 = start_total;
    set_req(2, no_op, 8'h11, 8'h22);
    @(negedge clk);
    chk("noop_ack", ack, 4'b0100);
    chk("noop_result", rsp_result, 16'h0000);
    chk("noop_err", rsp_err, 1'b0);
    req[2] = 1'b0;
    @(negedge clk);
    chk("noop_ack_clear", ack, 4'b0000);
    chk("noop_idle", busy, 1'b0);
    set_req(2, rst_op, 8'h33, 8'h44);
    @(negedge clk);
    chk("rstop_ack", ack, 4'b0100);
    chk("rstop_result", rsp_result, 16'h0000);
    req[2] = 1'b0;
    @(negedge clk);
    chk("local_no_start", start_total - s0, 0);

    // Timeout, then a normal operation
    alu_hang = 1'b1;
    s0 = start_total;
    set_req(0, xor_op, 8'h5A, 8'hFF);
    collect(1, 40);
    if (res_q.size() == 1) begin
      chk("to_order", order_q[0], 0);
      chk("to_err", err_q[0], 1'b1);
      chk("to_result", res_q[0], 16'hFFFF);
    end
    chk("to_start_cycles", start_total - s0, TO);
    alu_hang = 1'b0;
    set_req(0, xor_op, 8'h5A, 8'h0F);
    collect(1, 20);
    if (res_q.size() == 1) begin
      chk("after_to_result", res_q[0], 16'h0055);
      chk("after_to_err", err_q[0], 1'b0);
    end

    // Reset during ISSUE of a mul on requester 1
    set_req(1, mul_op, 8'h10, 8'h10);
    wait_start(5);
    reset_n = 1'b0;
    req = '0;
    #1;
    chk("mid_rst_start", alu_start, 1'b0);
    chk("mid_rst_ack", ack, 4'b0000);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_alu_op", alu_op, no_op);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack != '0) acks++;
    end
    chk("no_stale_ack", acks, 0);
    // Pointer back at 0: requester 0 beats requester 1
    set_req(0, add_op, 8'h01, 8'h02);
    set_req(1, add_op, 8'hFF, 8'h01);
    collect(2, 30);
    if (order_q.size() == 2) begin
      chk("ptr0_first", order_q[0], 0);
      chk("ptr0_first_result", res_q[0], 16'h0003);
      chk("ptr0_second", order_q[1], 1);
      chk("ptr0_second_result", res_q[1], 16'h0100);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
